// File: rtl/fwdu_sb_pkg.sv
// Shared CPU width defaults and scoreboard sizing used by the forwarding unit.
// Entry fields are valid / rd / rdy / data, held as parallel packed arrays in fwdu_sb.
package fwdu_sb_pkg;

    localparam int unsigned FWDU_REGNO_WIDTH = 5;
    localparam int unsigned FWDU_REG_WIDTH   = 32;
    localparam int unsigned FWDU_DEPTH       = 3;
    localparam int unsigned FWDU_NRD         = 2;

endpackage

// File: rtl/fwdu_sb_lookup.sv
// Youngest-match search of one source operand against the in-flight scoreboard.
// Entry 0 is the youngest, so the lowest matching index wins.
module fwdu_sb_lookup
    import fwdu_sb_pkg::*;
#(
    parameter int unsigned REGNO_WIDTH = FWDU_REGNO_WIDTH,
    parameter int unsigned REG_WIDTH   = FWDU_REG_WIDTH,
    parameter int unsigned DEPTH       = FWDU_DEPTH
) (
    input  logic [REGNO_WIDTH-1:0]       rd_no_i,
    input  logic [REG_WIDTH-1:0]         rd_data_i,
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [DEPTH*REGNO_WIDTH-1:0] rd_i,
    input  logic [DEPTH-1:0]             rdy_e_i,
    input  logic [DEPTH*REG_WIDTH-1:0]   data_e_i,
    output logic [REG_WIDTH-1:0]         fwd_data_o,
    output logic                         hazard_o
);

    logic                 hit_s;
    logic                 hit_rdy_s;
    logic [REG_WIDTH-1:0] hit_data_s;

    // Scan oldest to youngest so a younger match overwrites any older one.
    always_comb begin
        hit_s      = 1'b0;
        hit_rdy_s  = 1'b0;
        hit_data_s = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (valid_i[k] && (rd_i[k*REGNO_WIDTH +: REGNO_WIDTH] == rd_no_i)) begin
                hit_s      = 1'b1;
                hit_rdy_s  = rdy_e_i[k];
                hit_data_s = data_e_i[k*REG_WIDTH +: REG_WIDTH];
            end else begin
                hit_s      = hit_s;
            end
        end
    end

    // Register 0 bypasses the scoreboard entirely.
    always_comb begin
        if ((rd_no_i == '0) || !hit_s) begin
            fwd_data_o = rd_data_i;
            hazard_o   = 1'b0;
        end else begin
            fwd_data_o = hit_data_s;
            hazard_o   = !hit_rdy_s;
        end
    end

endmodule

// File: rtl/fwdu_sb.sv
// Scoreboard forwarding unit: tracks DEPTH in-flight destinations after decode,
// forwards the youngest value to NRD decode operands and stalls on load-use.
module fwdu_sb
    import fwdu_sb_pkg::*;
#(
    parameter int unsigned REGNO_WIDTH = FWDU_REGNO_WIDTH,
    parameter int unsigned REG_WIDTH   = FWDU_REG_WIDTH,
    parameter int unsigned DEPTH       = FWDU_DEPTH,
    parameter int unsigned NRD         = FWDU_NRD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hold,
    input  logic                       flush,
    input  logic                       iss_wr,
    input  logic [REGNO_WIDTH-1:0]     iss_rd,
    input  logic                       iss_rdy,
    input  logic [REG_WIDTH-1:0]       iss_data,
    input  logic [DEPTH-1:0]           res_en,
    input  logic [DEPTH*REG_WIDTH-1:0] res_data,
    input  logic [NRD*REGNO_WIDTH-1:0] rd_no,
    input  logic [NRD*REG_WIDTH-1:0]   rd_data,
    output logic [NRD*REG_WIDTH-1:0]   fwd_data,
    output logic                       stall
);

    logic [DEPTH-1:0]                  valid_q, valid_d;
    logic [DEPTH-1:0]                  rdy_q, rdy_d;
    logic [DEPTH-1:0][REGNO_WIDTH-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][REG_WIDTH-1:0]   data_q, data_d;

    logic [DEPTH-1:0]                  rdy_e_s;
    logic [DEPTH-1:0][REG_WIDTH-1:0]   data_e_s;
    logic [NRD-1:0]                    hazard_s;
    logic                              stall_s;

    // Effective entry view: a result arriving this cycle counts as ready now.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            rdy_e_s[k] = rdy_q[k] | (res_en[k] & valid_q[k]);
            if (res_en[k] && valid_q[k]) begin
                data_e_s[k] = res_data[k*REG_WIDTH +: REG_WIDTH];
            end else begin
                data_e_s[k] = data_q[k];
            end
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_port
        fwdu_sb_lookup #(
            .REGNO_WIDTH (REGNO_WIDTH),
            .REG_WIDTH   (REG_WIDTH),
            .DEPTH       (DEPTH)
        ) u_lookup (
            .rd_no_i    (rd_no[j*REGNO_WIDTH +: REGNO_WIDTH]),
            .rd_data_i  (rd_data[j*REG_WIDTH +: REG_WIDTH]),
            .valid_i    (valid_q),
            .rd_i       (rd_q),
            .rdy_e_i    (rdy_e_s),
            .data_e_i   (data_e_s),
            .fwd_data_o (fwd_data[j*REG_WIDTH +: REG_WIDTH]),
            .hazard_o   (hazard_s[j])
        );
    end

    // A flush already empties the pipe, so it also cancels this cycle's stall.
    assign stall_s = (|hazard_s) & ~flush;
    assign stall   = stall_s;

    // Next-state: flush, then hold (absorb results in place), then shift with issue or bubble.
    always_comb begin
        valid_d = valid_q;
        rdy_d   = rdy_q;
        rd_d    = rd_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
            rdy_d   = '0;
        end else if (hold) begin
            rdy_d  = rdy_e_s;
            data_d = data_e_s;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                valid_d[k] = valid_q[k-1];
                rd_d[k]    = rd_q[k-1];
                rdy_d[k]   = rdy_e_s[k-1];
                data_d[k]  = data_e_s[k-1];
            end
            if (stall_s) begin
                valid_d[0] = 1'b0;
                rd_d[0]    = '0;
                rdy_d[0]   = 1'b0;
                data_d[0]  = '0;
            end else begin
                valid_d[0] = iss_wr && (iss_rd != '0);
                rd_d[0]    = iss_rd;
                rdy_d[0]   = iss_rdy;
                data_d[0]  = iss_data;
            end
        end
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            rdy_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_fwdu_sb.sv
// Directed self-checking bench for fwdu_sb with default parameters.
module tb_fwdu_sb;

    localparam int RNW = 5;
    localparam int RW  = 32;
    localparam int DP  = 3;
    localparam int NR  = 2;

    logic              clk;
    logic              rst;
    logic              hold;
    logic              flush;
    logic              iss_wr;
    logic [RNW-1:0]    iss_rd;
    logic              iss_rdy;
    logic [RW-1:0]     iss_data;
    logic [DP-1:0]     res_en;
    logic [DP*RW-1:0]  res_data;
    logic [NR*RNW-1:0] rd_no;
    logic [NR*RW-1:0]  rd_data;
    logic [NR*RW-1:0]  fwd_data;
    logic              stall;

    int checks;
    int failures;

    fwdu_sb #(.REGNO_WIDTH(RNW), .REG_WIDTH(RW), .DEPTH(DP), .NRD(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .flush    (flush),
        .iss_wr   (iss_wr),
        .iss_rd   (iss_rd),
        .iss_rdy  (iss_rdy),
        .iss_data (iss_data),
        .res_en   (res_en),
        .res_data (res_data),
        .rd_no    (rd_no),
        .rd_data  (rd_data),
        .fwd_data (fwd_data),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        hold     = 1'b0;
        flush    = 1'b0;
        iss_wr   = 1'b0;
        iss_rd   = '0;
        iss_rdy  = 1'b0;
        iss_data = '0;
        res_en   = '0;
        res_data = '0;
    endtask

    task automatic set_rd(input int j, input logic [RNW-1:0] no, input logic [RW-1:0] d);
        rd_no[j*RNW +: RNW] = no;
        rd_data[j*RW +: RW] = d;
    endtask

    task automatic issue(input logic [RNW-1:0] r, input logic rdy, input logic [RW-1:0] d);
        iss_wr   = 1'b1;
        iss_rd   = r;
        iss_rdy  = rdy;
        iss_data = d;
    endtask

    task automatic result(input int k, input logic [RW-1:0] d);
        res_en[k]            = 1'b1;
        res_data[k*RW +: RW] = d;
    endtask

    // Advance one cycle: inputs change right after the falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rd_no   = '0;
        rd_data = '0;
        rst     = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        set_rd(0, 5'd5, 32'h11);
        set_rd(1, 5'd7, 32'h22);
        #1;
        checks++;
        if (fwd_data[0 +: RW] !== 32'h11) begin
            failures++; $display("FAIL reset_fwd0 got=%h exp=%h", fwd_data[0 +: RW], 32'h11);
        end
        checks++;
        if (fwd_data[RW +: RW] !== 32'h22) begin
            failures++; $display("FAIL reset_fwd1 got=%h exp=%h", fwd_data[RW +: RW], 32'h22);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL reset_stall got=%b exp=0", stall);
        end
    endtask

    task automatic test_alu_chain();
        idle();
        set_rd(0, 5'd1, 32'h1); set_rd(1, 5'd2, 32'h2);
        issue(5'd5, 1'b0, 32'h0);
        cyc();
        idle();
        result(0, 32'hAAAA);
        set_rd(0, 5'd5, 32'h5);
        #1;
        checks++;
        if (fwd_data[0 +: RW] !== 32'hAAAA || stall !== 1'b0) begin
            failures++; $display("FAIL alu_same_cycle got=%h/%b exp=%h/0", fwd_data[0 +: RW], stall, 32'hAAAA);
        end
        cyc();
        idle();
        set_rd(0, 5'd6, 32'h66); set_rd(1, 5'd5, 32'h5);
        #1;
        checks++;
        if (fwd_data[RW +: RW] !== 32'hAAAA || stall !== 1'b0) begin
            failures++; $display("FAIL alu_entry1 got=%h/%b exp=%h/0", fwd_data[RW +: RW], stall, 32'hAAAA);
        end
        checks++;
        if (fwd_data[0 +: RW] !== 32'h66) begin
            failures++; $display("FAIL alu_nomatch got=%h exp=%h", fwd_data[0 +: RW], 32'h66);
        end
        do_flush();
    endtask

    task automatic test_load_use();
        idle();
        set_rd(0, 5'd1, 32'h1); set_rd(1, 5'd2, 32'h2);
        issue(5'd3, 1'b0, 32'h0);
        cyc();
        issue(5'd4, 1'b1, 32'h44);
        set_rd(0, 5'd3, 32'h3);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("FAIL loaduse_stall got=%b exp=1", stall);
        end
        cyc();
        result(1, 32'hBEEF);
        set_rd(1, 5'd4, 32'h99);
        #1;
        checks++;
        if (fwd_data[0 +: RW] !== 32'hBEEF || stall !== 1'b0) begin
            failures++; $display("FAIL loaduse_fwd got=%h/%b exp=%h/0", fwd_data[0 +: RW], stall, 32'hBEEF);
        end
        checks++;
        if (fwd_data[RW +: RW] !== 32'h99) begin
            failures++; $display("FAIL loaduse_bubble got=%h exp=%h", fwd_data[RW +: RW], 32'h99);
        end
        cyc();
        idle();
        set_rd(0, 5'd4, 32'h4); set_rd(1, 5'd3, 32'h3);
        #1;
        checks++;
        if (fwd_data[0 +: RW] !== 32'h44 || fwd_data[RW +: RW] !== 32'hBEEF) begin
            failures++; $display("FAIL loaduse_after got=%h,%h exp=%h,%h",
                                 fwd_data[0 +: RW], fwd_data[RW +: RW], 32'h44, 32'hBEEF);
        end
        do_flush();
    endtask

    task automatic test_priority();
        idle();
        set_rd(0, 5'd1, 32'h1); set_rd(1, 5'd2, 32'h2);
        issue(5'd9, 1'b1, 32'h1);
        cyc();
        issue(5'd0, 1'b0, 32'h0);
        cyc();
        issue(5'd9, 1'b1, 32'h2);
        cyc();
        idle();
        set_rd(0, 5'd9, 32'h9); set_rd(1, 5'd0, 32'h77);
        #1;
        checks++;
        if (fwd_data[0 +: RW] !== 32'h2) begin
            failures++; $display("FAIL prio_youngest got=%h exp=%h", fwd_data[0 +: RW], 32'h2);
        end
        checks++;
        if (fwd_data[RW +: RW] !== 32'h77 || stall !== 1'b0) begin
            failures++; $display("FAIL prio_r0 got=%h/%b exp=%h/0", fwd_data[RW +: RW], stall, 32'h77);
        end
        do_flush();
    endtask

    task automatic test_hold();
        idle();
        set_rd(0, 5'd1, 32'h1); set_rd(1, 5'd2, 32'h2);
        issue(5'd8, 1'b0, 32'h0);
        cyc();
        hold = 1'b1;
        issue(5'd10, 1'b1, 32'hA0);
        result(0, 32'h55);
        cyc();
        res_en = '0;
        cyc();
        result(1, 32'h77);
        set_rd(0, 5'd8, 32'h8); set_rd(1, 5'd10, 32'hAA);
        #1;
        checks++;
        if (fwd_data[0 +: RW] !== 32'h55 || stall !== 1'b0) begin
            failures++; $display("FAIL hold_entry0 got=%h/%b exp=%h/0", fwd_data[0 +: RW], stall, 32'h55);
        end
        checks++;
        if (fwd_data[RW +: RW] !== 32'hAA) begin
            failures++; $display("FAIL hold_noissue got=%h exp=%h", fwd_data[RW +: RW], 32'hAA);
        end
        cyc();
        idle();
        cyc();
        result(1, 32'h33);
        #1;
        checks++;
        if (fwd_data[0 +: RW] !== 32'h33) begin
            failures++; $display("FAIL hold_shifted got=%h exp=%h", fwd_data[0 +: RW], 32'h33);
        end
        do_flush();
    endtask

    task automatic test_flush();
        idle();
        set_rd(0, 5'd1, 32'h1); set_rd(1, 5'd2, 32'h2);
        issue(5'd3, 1'b0, 32'h0);
        cyc();
        idle();
        set_rd(0, 5'd3, 32'h30);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("FAIL flush_prestall got=%b exp=1", stall);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL flush_wins got=%b exp=0", stall);
        end
        cyc();
        idle();
        #1;
        checks++;
        if (fwd_data[0 +: RW] !== 32'h30 || stall !== 1'b0) begin
            failures++; $display("FAIL flush_cleared got=%h/%b exp=%h/0", fwd_data[0 +: RW], stall, 32'h30);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        set_rd(0, 5'd1, 32'h1); set_rd(1, 5'd2, 32'h2);
        issue(5'd6, 1'b0, 32'h0);
        cyc();
        issue(5'd7, 1'b0, 32'h0);
        set_rd(0, 5'd6, 32'h60);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("FAIL rstmid_prestall got=%b exp=1", stall);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || fwd_data[0 +: RW] !== 32'h60) begin
            failures++; $display("FAIL rstmid_async got=%h/%b exp=%h/0", fwd_data[0 +: RW], stall, 32'h60);
        end
        cyc();
        rst = 1'b0;
        idle();
        set_rd(1, 5'd7, 32'h70);
        #1;
        checks++;
        if (stall !== 1'b0 || fwd_data[RW +: RW] !== 32'h70) begin
            failures++; $display("FAIL rstmid_after got=%h/%b exp=%h/0", fwd_data[RW +: RW], stall, 32'h70);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        rd_no    = '0;
        rd_data  = '0;
        @(negedge clk);
        test_reset();
        test_alu_chain();
        test_load_use();
        test_priority();
        test_hold();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
